// File: rtl/add_subt_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------------------
// add_subt_pipe - multi-source elastic-pipelined adder/subtractor with P/G for the LZA
// Revision 1.0
// ------------------------------------------------------------------------------------
module add_subt_pipe #(
  parameter int SW   = 26,
  parameter int NSRC = 2,
  parameter int LAT  = 1,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*SW-1:0]   Oper_A_i,
  input  logic [NSRC*SW-1:0]   Oper_B_i,
  input  logic [NSRC-1:0]      Add_Sub_i,
  input  logic [SELW-1:0]      Sel_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [SW-1:0]        Data_Result_o,
  output logic [SW-1:0]        P_o,
  output logic [SW-1:0]        G_o,
  output logic                 C_o,
  output logic                 Z_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  logic [SW-1:0] a_sel;
  logic [SW-1:0] b_sel;
  logic          op_sel;
  logic [SW-1:0] b_inv;
  logic [SW-1:0] prop;
  logic [SW-1:0] gen;
  logic          load_in;

  // Out-of-range selects never match a source index and fall back to source 0.
  always_comb begin
    a_sel  = Oper_A_i[SW-1:0];
    b_sel  = Oper_B_i[SW-1:0];
    op_sel = Add_Sub_i[0];
    for (int k = 1; k < NSRC; k++) begin
      if (int'(Sel_i) == k) begin
        a_sel  = Oper_A_i[k*SW +: SW];
        b_sel  = Oper_B_i[k*SW +: SW];
        op_sel = Add_Sub_i[k];
      end
    end
  end

  assign b_inv      = b_sel ^ {SW{op_sel}};
  assign prop       = a_sel ^ b_inv;
  assign gen        = a_sel & b_inv;
  assign in_ready_o = load_in & ~rst;

  if (LAT == 1) begin : g_lat1
    logic [SW:0]   sum_d;
    logic          v_q;
    logic [SW-1:0] s_q;
    logic [SW-1:0] p_q;
    logic [SW-1:0] g_q;
    logic          c_q;
    logic          z_q;

    assign sum_d   = {1'b0, a_sel} + {1'b0, b_inv} + {{SW{1'b0}}, op_sel};
    assign load_in = ~v_q | out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        p_q <= '0;
        g_q <= '0;
        c_q <= 1'b0;
        z_q <= 1'b0;
      end else if (load_in) begin
        v_q <= in_valid_i;
        if (in_valid_i) begin
          s_q <= sum_d[SW-1:0];
          c_q <= sum_d[SW];
          z_q <= ~|sum_d[SW-1:0];
          p_q <= prop;
          g_q <= gen;
        end
      end
    end

    assign Data_Result_o = s_q;
    assign P_o           = p_q;
    assign G_o           = g_q;
    assign C_o           = c_q;
    assign Z_o           = z_q;
    assign out_valid_o   = v_q;
  end else begin : g_lat2
    localparam int LO = SW / 2;
    localparam int HI = SW - LO;

    logic [LO:0]   lo_d;
    logic [HI:0]   hi_d;
    logic          load_2;

    logic          v1_q;
    logic [LO-1:0] slo_q;
    logic          clo_q;
    logic [HI-1:0] ahi_q;
    logic [HI-1:0] bhi_q;
    logic [SW-1:0] p1_q;
    logic [SW-1:0] g1_q;

    logic          v2_q;
    logic [SW-1:0] s2_q;
    logic [SW-1:0] p2_q;
    logic [SW-1:0] g2_q;
    logic          c2_q;
    logic          z2_q;

    // Low half resolves in stage 1; its carry seeds the high half in stage 2.
    assign lo_d    = {1'b0, a_sel[LO-1:0]} + {1'b0, b_inv[LO-1:0]} + {{LO{1'b0}}, op_sel};
    assign hi_d    = {1'b0, ahi_q} + {1'b0, bhi_q} + {{HI{1'b0}}, clo_q};
    assign load_2  = ~v2_q | out_ready_i;
    assign load_in = ~v1_q | load_2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1_q  <= 1'b0;
        slo_q <= '0;
        clo_q <= 1'b0;
        ahi_q <= '0;
        bhi_q <= '0;
        p1_q  <= '0;
        g1_q  <= '0;
      end else if (load_in) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          slo_q <= lo_d[LO-1:0];
          clo_q <= lo_d[LO];
          ahi_q <= a_sel[SW-1:LO];
          bhi_q <= b_inv[SW-1:LO];
          p1_q  <= prop;
          g1_q  <= gen;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q <= 1'b0;
        s2_q <= '0;
        p2_q <= '0;
        g2_q <= '0;
        c2_q <= 1'b0;
        z2_q <= 1'b0;
      end else if (load_2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_q <= {hi_d[HI-1:0], slo_q};
          c2_q <= hi_d[HI];
          z2_q <= ~|{hi_d[HI-1:0], slo_q};
          p2_q <= p1_q;
          g2_q <= g1_q;
        end
      end
    end

    assign Data_Result_o = s2_q;
    assign P_o           = p2_q;
    assign G_o           = g2_q;
    assign C_o           = c2_q;
    assign Z_o           = z2_q;
    assign out_valid_o   = v2_q;
  end

endmodule
`default_nettype wire
